// File: rtl/syn_lb_mstr.sv
// Local-bus master: turns single host read/write commands into LB strobes,
// waits for the matching slave valid (bounded by a timeout) and returns one response.
module syn_lb_mstr #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk_ir,
  input  logic              rst_sync_l,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              lb_rd_en,
  output logic              lb_wr_en,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0] lb_wr_data,
  input  logic              lb_rd_valid,
  input  logic              lb_wr_valid,
  input  logic [DATA_W-1:0] lb_rd_data,
  output logic              busy,
  output logic [15:0]       tout_cnt
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   tmo, tmo_d;
  logic               dir_wr, dir_wr_d;
  logic               rsp_match;
  logic               rsp_valid_d, rsp_wr_d, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_d;
  logic               lb_rd_en_d, lb_wr_en_d;
  logic [ADDR_W-1:0]  lb_addr_d;
  logic [DATA_W-1:0]  lb_wr_data_d;
  logic [15:0]        tout_cnt_d;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Only a valid of the same direction as the pending command completes it.
  assign rsp_match = dir_wr ? lb_wr_valid : lb_rd_valid;

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      state      <= S_IDLE;
      tmo        <= '0;
      dir_wr     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_wr     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      lb_rd_en   <= 1'b0;
      lb_wr_en   <= 1'b0;
      lb_addr    <= '0;
      lb_wr_data <= '0;
      tout_cnt   <= '0;
    end else begin
      state      <= state_d;
      tmo        <= tmo_d;
      dir_wr     <= dir_wr_d;
      rsp_valid  <= rsp_valid_d;
      rsp_wr     <= rsp_wr_d;
      rsp_err    <= rsp_err_d;
      rsp_rdata  <= rsp_rdata_d;
      lb_rd_en   <= lb_rd_en_d;
      lb_wr_en   <= lb_wr_en_d;
      lb_addr    <= lb_addr_d;
      lb_wr_data <= lb_wr_data_d;
      tout_cnt   <= tout_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    tmo_d        = tmo;
    dir_wr_d     = dir_wr;
    rsp_valid_d  = rsp_valid;
    rsp_wr_d     = rsp_wr;
    rsp_err_d    = rsp_err;
    rsp_rdata_d  = rsp_rdata;
    lb_rd_en_d   = 1'b0;
    lb_wr_en_d   = 1'b0;
    lb_addr_d    = lb_addr;
    lb_wr_data_d = lb_wr_data;
    tout_cnt_d   = tout_cnt;

    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_d      = S_ISSUE;
          tmo_d        = '0;
          dir_wr_d     = req_wr;
          lb_addr_d    = req_addr;
          lb_wr_data_d = req_wdata;
          lb_wr_en_d   = req_wr;
          lb_rd_en_d   = !req_wr;
        end
      end
      S_ISSUE, S_WAIT: begin
        tmo_d = tmo + CNT_W'(1);
        // A match in the final timeout cycle still completes without error.
        if (rsp_match) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = dir_wr;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = dir_wr ? '0 : lb_rd_data;
        end else if (tmo == TMO_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = dir_wr;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          if (tout_cnt != 16'hFFFF) begin
            tout_cnt_d = tout_cnt + 16'd1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_syn_lb_mstr.sv
// Bench for syn_lb_mstr: age-based transaction model checked every cycle,
// plus directed transactions with hand-computed latencies and data.
module tb_syn_lb_mstr;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        lb_rd_en;
  logic        lb_wr_en;
  logic [11:0] lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_rd_valid = 1'b0;
  logic        lb_wr_valid = 1'b0;
  logic [31:0] lb_rd_data = '0;
  logic        busy;
  logic [15:0] tout_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  syn_lb_mstr #(.DATA_W(32), .ADDR_W(12), .TIMEOUT_CYC(TO)) dut (
    .clk_ir(clk), .rst_sync_l(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .lb_rd_en(lb_rd_en), .lb_wr_en(lb_wr_en), .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data), .lb_rd_valid(lb_rd_valid),
    .lb_wr_valid(lb_wr_valid), .lb_rd_data(lb_rd_data),
    .busy(busy), .tout_cnt(tout_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: a command is "in flight" with an age (1 = strobe cycle) until a
  // same-direction valid arrives or the age reaches TO; then a response is held.
  logic        m_inflight, m_rsp, m_wr, m_rwr, m_rerr;
  int          m_age, m_tout;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 1'b0; m_rsp <= 1'b0; m_wr <= 1'b0; m_age <= 0; m_tout <= 0;
      m_addr <= '0; m_wdata <= '0; m_rwr <= 1'b0; m_rerr <= 1'b0; m_rdata <= '0;
    end else if (m_rsp) begin
      if (rsp_ready) m_rsp <= 1'b0;
    end else if (m_inflight) begin
      if (m_wr ? lb_wr_valid : lb_rd_valid) begin
        m_inflight <= 1'b0; m_rsp <= 1'b1; m_rwr <= m_wr; m_rerr <= 1'b0;
        m_rdata <= m_wr ? 32'd0 : lb_rd_data;
      end else if (m_age == TO) begin
        m_inflight <= 1'b0; m_rsp <= 1'b1; m_rwr <= m_wr; m_rerr <= 1'b1;
        m_rdata <= 32'd0;
        m_tout <= (m_tout == 65535) ? m_tout : m_tout + 1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (req_valid) begin
      m_inflight <= 1'b1; m_age <= 1; m_wr <= req_wr;
      m_addr <= req_addr; m_wdata <= req_wdata;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_req_ready", 32'(req_ready), 32'(!m_inflight && !m_rsp));
      chk("m_busy", 32'(busy), 32'(m_inflight || m_rsp));
      chk("m_rd_en", 32'(lb_rd_en), 32'(m_inflight && m_age == 1 && !m_wr));
      chk("m_wr_en", 32'(lb_wr_en), 32'(m_inflight && m_age == 1 && m_wr));
      chk("m_addr", 32'(lb_addr), 32'(m_addr));
      chk("m_wdata", lb_wr_data, m_wdata);
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      chk("m_tout_cnt", 32'(tout_cnt), 32'(m_tout));
      if (m_rsp) begin
        chk("m_rsp_wr", 32'(rsp_wr), 32'(m_rwr));
        chk("m_rsp_err", 32'(rsp_err), 32'(m_rerr));
        chk("m_rsp_rdata", rsp_rdata, m_rdata);
      end
    end
  end

  // One transaction; rd_k/wr_k are cycle offsets from accept for slave valids (0 = none).
  task automatic txn(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input int rd_k, input int wr_k, input logic [31:0] rdat,
                     input int hold, input int exp_k, input bit exp_err,
                     input logic [31:0] exp_rd);
    int t0, k, seen, last, n;
    bit done;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    t0 = cyc; req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    seen = -1; done = 1'b0; k = 0;
    last = (rd_k > wr_k) ? rd_k : wr_k;
    while ((!done || k < last) && k < exp_k + hold + 20) begin
      @(negedge clk);
      k = cyc - t0;
      req_valid = 1'b0; rsp_ready = 1'b0;
      lb_rd_valid = (k == rd_k); lb_wr_valid = (k == wr_k);
      lb_rd_data = (k == rd_k) ? rdat : $urandom;
      if (k == 1) begin
        chk("strobe_rd", 32'(lb_rd_en), 32'(!wr));
        chk("strobe_wr", 32'(lb_wr_en), 32'(wr));
        chk("strobe_addr", 32'(lb_addr), 32'(a));
        chk("strobe_wdata", lb_wr_data, d);
      end
      if (k == 2) chk("strobe_off", 32'(lb_rd_en | lb_wr_en), 32'd0);
      if (!done && rsp_valid) begin
        if (seen < 0) begin seen = k; chk("rsp_latency", 32'(k), 32'(exp_k)); end
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_wr", 32'(rsp_wr), 32'(wr));
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        if (k - seen >= hold) begin rsp_ready = 1'b1; done = 1'b1; end
      end
    end
    chk("rsp_seen", 32'(done), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0; lb_rd_valid = 1'b0; lb_wr_valid = 1'b0;
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_tout_cnt", 32'(tout_cnt), 32'd0);
    chk_on = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray valids while idle must be ignored.
    lb_rd_valid = 1'b1; lb_wr_valid = 1'b1; lb_rd_data = 32'h1234_5678;
    repeat (3) @(negedge clk);
    lb_rd_valid = 1'b0; lb_wr_valid = 1'b0;
    chk("idle_stray", 32'(rsp_valid), 32'd0);

    txn(1'b0, 12'h010, 32'h0, 3, 0, 32'hCAFE_0001, 0, 4, 1'b0, 32'hCAFE_0001);
    txn(1'b1, 12'h104, 32'h5A5A_5A5A, 0, 1, 32'h0, 0, 2, 1'b0, 32'h0);
    txn(1'b0, 12'h020, 32'h0, 70, 0, 32'hDEAD_BEEF, 0, 65, 1'b1, 32'h0);
    chk("tout_after_timeout", 32'(tout_cnt), 32'd1);
    txn(1'b0, 12'h030, 32'h0, 5, 2, 32'h0BAD_F00D, 0, 6, 1'b0, 32'h0BAD_F00D);
    txn(1'b0, 12'h040, 32'h0, TO, 0, 32'h7777_0001, 0, 65, 1'b0, 32'h7777_0001);
    txn(1'b1, 12'h050, 32'hA5A5_0000, 3, 0, 32'h0, 0, 65, 1'b1, 32'h0);
    chk("tout_after_wr_timeout", 32'(tout_cnt), 32'd2);
    txn(1'b1, 12'h060, 32'h1111_2222, 0, 4, 32'h0, 10, 5, 1'b0, 32'h0);

    // Reset pulse while waiting for a slave.
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 12'h070;
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_strobe", 32'(lb_rd_en | lb_wr_en), 32'd0);
    chk("rst_mid_addr", 32'(lb_addr), 32'd0);
    chk("rst_mid_tout", 32'(tout_cnt), 32'd0);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk_on = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    txn(1'b0, 12'hFFF, 32'h0, 2, 0, 32'h0000_00C3, 2, 3, 1'b0, 32'h0000_00C3);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
